// File: rtl/sram_seq_pkg.sv
// Shared definitions for the SRAM access sequencer: packet layout, idle packet,
// FSM state encoding and the packet builder used in the ISSUE cycle.
package sram_seq_pkg;

    localparam int PKT_W       = 55;
    localparam int ENA_BIT     = 54;
    localparam int WEN_BIT     = 53;
    localparam int MASK_LSB    = 49;
    localparam int ADDR_LSB    = 41;
    localparam int WDATA_LSB   = 9;
    localparam int ENA_RO_BIT  = 8;
    localparam int ADDR_RO_LSB = 0;

    typedef logic [PKT_W-1:0] packet_t;

    // Both enables and the write enable are active-low, so "nothing happening"
    // means those three bits high and every other field zero.
    localparam packet_t IDLE_PKT = {1'b1, 1'b1, 4'h0, 8'h00, 32'h0000_0000, 1'b1, 8'h00};

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        WRDONE,
        GAP
    } state_t;

    // The RO port ignores the write enable; RW reads leave mask and data at zero.
    function automatic packet_t build_packet(
        input logic       we,
        input logic       port,
        input logic [7:0] addr,
        input logic [31:0] wdata,
        input logic [3:0] wmask
    );
        packet_t pkt;
        pkt = IDLE_PKT;
        if (port) begin
            pkt[ENA_RO_BIT]          = 1'b0;
            pkt[ADDR_RO_LSB +: 8]    = addr;
        end else begin
            pkt[ENA_BIT]             = 1'b0;
            pkt[ADDR_LSB +: 8]       = addr;
            if (we) begin
                pkt[WEN_BIT]         = 1'b0;
                pkt[MASK_LSB +: 4]   = wmask;
                pkt[WDATA_LSB +: 32] = wdata;
            end
        end
        return pkt;
    endfunction

endpackage

// File: rtl/sram_access_sequencer_arb.sv
// Two-way round-robin arbiter. Holds the previous winner so that, when both
// requesters are valid, the one that did not win last time goes first.
module rr_arb2 (
    input  logic clk_in,
    input  logic rst,
    input  logic idle_i,
    input  logic valid0_i,
    input  logic valid1_i,
    output logic grant_o,
    output logic ready0_o,
    output logic ready1_o
);

    logic last_grant_q;
    logic last_grant_d;

    // Choose this cycle's winner from the live valids; ready only while idle and not in reset
    always_comb begin
        grant_o = 1'b0;
        if (valid0_i && valid1_i) begin
            grant_o = ~last_grant_q;
        end else if (valid1_i) begin
            grant_o = 1'b1;
        end
        ready0_o     = !rst && idle_i && valid0_i && !grant_o;
        ready1_o     = !rst && idle_i && valid1_i && grant_o;
        last_grant_d = last_grant_q;
        if (ready0_o || ready1_o) begin
            last_grant_d = grant_o;
        end
    end

    // Remember the last accepted requester; starts at 1 so requester 0 wins the first tie
    always_ff @(posedge clk_in) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/sram_access_sequencer.sv
// Sequences single outstanding accesses to the two test-chip SRAM macros:
// arbitrates the two requesters, drives the access packet for one cycle,
// waits out the read pipeline and returns the captured word in issue order.
module sram_access_sequencer #(
    parameter int unsigned RD_LAT = 4,
    parameter int unsigned WR_GAP = 2
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic        req0_we_i,
    input  logic        req0_port_i,
    input  logic        req0_sram_i,
    input  logic [7:0]  req0_addr_i,
    input  logic [31:0] req0_wdata_i,
    input  logic [3:0]  req0_wmask_i,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic        req1_we_i,
    input  logic        req1_port_i,
    input  logic        req1_sram_i,
    input  logic [7:0]  req1_addr_i,
    input  logic [31:0] req1_wdata_i,
    input  logic [3:0]  req1_wmask_i,
    output logic        rsp_valid_o,
    output logic        rsp_id_o,
    output logic [31:0] rsp_rdata_o,
    output logic [54:0] packet_o,
    output logic        chip_select_o,
    input  logic [31:0] rd_data_i,
    output logic        busy_o
);
    import sram_seq_pkg::*;

    localparam logic [3:0] RD_LOAD  = 4'(RD_LAT - 1);
    localparam logic [3:0] GAP_LOAD = 4'(WR_GAP);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        grant;
    logic        accept;
    logic        is_write;

    logic        owner_q;
    logic        we_q;
    logic        port_q;
    logic [7:0]  addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wmask_q;
    logic        cs_q;
    logic [31:0] rdata_q;

    rr_arb2 u_arb (
        .clk_in   (clk_in),
        .rst      (rst),
        .idle_i   (state_q == IDLE),
        .valid0_i (req0_valid_i),
        .valid1_i (req1_valid_i),
        .grant_o  (grant),
        .ready0_o (req0_ready_o),
        .ready1_o (req1_ready_o)
    );

    assign accept   = (req0_valid_i && req0_ready_o) || (req1_valid_i && req1_ready_o);
    assign is_write = we_q && !port_q;

    // Latch the winning request; chip_select follows it and then holds until the next acceptance
    always_ff @(posedge clk_in) begin
        if (rst) begin
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            port_q  <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 32'h0;
            wmask_q <= 4'h0;
            cs_q    <= 1'b0;
        end else if (accept) begin
            owner_q <= grant;
            if (grant) begin
                we_q    <= req1_we_i;
                port_q  <= req1_port_i;
                addr_q  <= req1_addr_i;
                wdata_q <= req1_wdata_i;
                wmask_q <= req1_wmask_i;
                cs_q    <= req1_sram_i;
            end else begin
                we_q    <= req0_we_i;
                port_q  <= req0_port_i;
                addr_q  <= req0_addr_i;
                wdata_q <= req0_wdata_i;
                wmask_q <= req0_wmask_i;
                cs_q    <= req0_sram_i;
            end
        end
    end

    // Capture the returned word in the last cycle of the read wait
    always_ff @(posedge clk_in) begin
        if (rst) begin
            rdata_q <= 32'h0;
        end else if (state_q == WAIT && cnt_q == 4'd0) begin
            rdata_q <= rd_data_i;
        end
    end

    // FSM state and shared wait/gap counter
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the counter reaching zero ends both the read wait and the write gap
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (is_write) begin
                    state_d = WRDONE;
                end else begin
                    state_d = WAIT;
                    cnt_d   = RD_LOAD;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            WRDONE: begin
                if (WR_GAP == 0) begin
                    state_d = IDLE;
                end else begin
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                end
            end
            GAP: begin
                if (cnt_q <= 4'd1) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Outputs decoded from the registered state; the packet is live only during ISSUE
    always_comb begin
        packet_o = IDLE_PKT;
        if (state_q == ISSUE) begin
            packet_o = build_packet(we_q, port_q, addr_q, wdata_q, wmask_q);
        end
        rsp_valid_o   = (state_q == RESP) || (state_q == WRDONE);
        rsp_id_o      = owner_q;
        rsp_rdata_o   = (state_q == RESP) ? rdata_q : 32'h0;
        chip_select_o = cs_q;
        busy_o        = (state_q != IDLE);
    end

endmodule

// File: tb/tb_sram_access_sequencer.sv
// Directed bench for sram_access_sequencer with hand-computed packets,
// response timing and arbitration order.
module tb_sram_access_sequencer;

    localparam int LAT = 4;
    localparam logic [54:0] IDLE_EXP = 55'h60_0000_0000_0100;

    logic        clk_in = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_we, req0_port, req0_sram;
    logic [7:0]  req0_addr;
    logic [31:0] req0_wdata;
    logic [3:0]  req0_wmask;
    logic        req1_valid, req1_ready, req1_we, req1_port, req1_sram;
    logic [7:0]  req1_addr;
    logic [31:0] req1_wdata;
    logic [3:0]  req1_wmask;
    logic        rsp_valid, rsp_id;
    logic [31:0] rsp_rdata;
    logic [54:0] packet;
    logic        chip_select;
    logic [31:0] rd_data;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;
    int who;

    always #5 clk_in = ~clk_in;

    sram_access_sequencer #(.RD_LAT(LAT), .WR_GAP(2)) dut (
        .clk_in        (clk_in),
        .rst           (rst),
        .req0_valid_i  (req0_valid),
        .req0_ready_o  (req0_ready),
        .req0_we_i     (req0_we),
        .req0_port_i   (req0_port),
        .req0_sram_i   (req0_sram),
        .req0_addr_i   (req0_addr),
        .req0_wdata_i  (req0_wdata),
        .req0_wmask_i  (req0_wmask),
        .req1_valid_i  (req1_valid),
        .req1_ready_o  (req1_ready),
        .req1_we_i     (req1_we),
        .req1_port_i   (req1_port),
        .req1_sram_i   (req1_sram),
        .req1_addr_i   (req1_addr),
        .req1_wdata_i  (req1_wdata),
        .req1_wmask_i  (req1_wmask),
        .rsp_valid_o   (rsp_valid),
        .rsp_id_o      (rsp_id),
        .rsp_rdata_o   (rsp_rdata),
        .packet_o      (packet),
        .chip_select_o (chip_select),
        .rd_data_i     (rd_data),
        .busy_o        (busy)
    );

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, got, exp);
        end
    endtask

    // Present a request on one requester and raise its valid
    task automatic applyStimulus(input int req, input logic we, input logic port, input logic sram,
                                 input logic [7:0] addr, input logic [31:0] wdata, input logic [3:0] wmask);
        if (req == 0) begin
            req0_we = we; req0_port = port; req0_sram = sram;
            req0_addr = addr; req0_wdata = wdata; req0_wmask = wmask; req0_valid = 1'b1;
        end else begin
            req1_we = we; req1_port = port; req1_sram = sram;
            req1_addr = addr; req1_wdata = wdata; req1_wmask = wmask; req1_valid = 1'b1;
        end
    endtask

    // Look for a ready in the current cycle, then on following cycles, within a bound
    task automatic waitGrant(output int w);
        w = -1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (req0_ready || req1_ready) begin
                w = req1_ready ? 1 : 0;
                checkOutput("ready_onehot", 64'(req0_ready) + 64'(req1_ready), 64'd1);
                break;
            end
            @(negedge clk_in);
        end
        checkOutput("grant_seen", 64'(w >= 0), 64'd1);
    endtask

    // Follow a read from its acceptance cycle through the response pulse
    task automatic trackRead(input string tag, input logic [54:0] expPkt, input logic expCs,
                             input logic expId, input logic [31:0] expData, input logic dropValid);
        for (int k = 1; k <= LAT + 2; k++) begin
            @(negedge clk_in);
            if (k == 1 && dropValid) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            rd_data = (k == LAT + 1) ? expData : ~expData;
            if (k == 1) begin
                checkOutput({tag, "_pkt"}, 64'(packet), 64'(expPkt));
                checkOutput({tag, "_cs"}, 64'(chip_select), 64'(expCs));
            end
            if (k == 2) checkOutput({tag, "_pkt_idle"}, 64'(packet), 64'(IDLE_EXP));
            checkOutput({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(k == LAT + 2));
            if (k == LAT + 2) begin
                checkOutput({tag, "_rsp_id"}, 64'(rsp_id), 64'(expId));
                checkOutput({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'(expData));
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        req0_valid = 0; req0_we = 0; req0_port = 0; req0_sram = 0; req0_addr = 0; req0_wdata = 0; req0_wmask = 0;
        req1_valid = 0; req1_we = 0; req1_port = 0; req1_sram = 0; req1_addr = 0; req1_wdata = 0; req1_wmask = 0;
        rd_data = 32'h0;
        @(negedge clk_in);
        @(negedge clk_in);
        checkOutput("rst_packet", 64'(packet), 64'(IDLE_EXP));
        checkOutput("rst_cs", 64'(chip_select), 64'd0);
        checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("rst_rsp_id", 64'(rsp_id), 64'd0);
        checkOutput("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_ready", {62'd0, req1_ready, req0_ready}, 64'd0);
        rst = 1'b0;

        // RW read from SRAM1 by requester 0
        @(negedge clk_in);
        applyStimulus(0, 1'b0, 1'b0, 1'b1, 8'h3C, 32'h0, 4'h0);
        waitGrant(who);
        checkOutput("rd_grant", 64'(who), 64'd0);
        trackRead("rd", {1'b0, 1'b1, 4'h0, 8'h3C, 32'h0, 1'b1, 8'h00}, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1);

        // RW write to SRAM0 by requester 1, valid held to probe the gap
        @(negedge clk_in);
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 8'h05, 32'h12345678, 4'hF);
        waitGrant(who);
        checkOutput("wr_grant", 64'(who), 64'd1);
        @(negedge clk_in);
        checkOutput("wr_pkt", 64'(packet), 64'({1'b0, 1'b0, 4'hF, 8'h05, 32'h12345678, 1'b1, 8'h00}));
        checkOutput("wr_cs", 64'(chip_select), 64'd0);
        checkOutput("wr_rsp_early", 64'(rsp_valid), 64'd0);
        @(negedge clk_in);
        checkOutput("wr_rsp_valid", 64'(rsp_valid), 64'd1);
        checkOutput("wr_rsp_id", 64'(rsp_id), 64'd1);
        checkOutput("wr_rsp_rdata", 64'(rsp_rdata), 64'd0);
        checkOutput("wr_ready_done", 64'(req1_ready), 64'd0);
        for (int g = 0; g < 2; g++) begin
            @(negedge clk_in);
            checkOutput("wr_gap_ready", 64'(req1_ready), 64'd0);
            checkOutput("wr_gap_busy", 64'(busy), 64'd1);
            checkOutput("wr_gap_rsp", 64'(rsp_valid), 64'd0);
        end
        @(negedge clk_in);
        #1;
        checkOutput("wr_after_gap_ready", 64'(req1_ready), 64'd1);
        req1_valid = 1'b0;

        // Both requesters valid for four reads: grants must alternate 0,1,0,1
        @(negedge clk_in);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 8'h10, 32'h0, 4'h0);
        applyStimulus(1, 1'b0, 1'b0, 1'b1, 8'h20, 32'h0, 4'h0);
        for (int t = 0; t < 4; t++) begin
            waitGrant(who);
            checkOutput("fair_grant", 64'(who), 64'(t % 2));
            if (t % 2 == 0)
                trackRead("fair0", {1'b0, 1'b1, 4'h0, 8'h10, 32'h0, 1'b1, 8'h00}, 1'b0, 1'b0,
                          32'hA000_0000 + 32'(t), 1'b0);
            else
                trackRead("fair1", {1'b0, 1'b1, 4'h0, 8'h20, 32'h0, 1'b1, 8'h00}, 1'b1, 1'b1,
                          32'hA000_0000 + 32'(t), 1'b0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // RO port read: write enable must be ignored
        @(negedge clk_in);
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 8'hA0, 32'hFFFF_FFFF, 4'hF);
        waitGrant(who);
        checkOutput("ro_grant", 64'(who), 64'd0);
        trackRead("ro", {1'b1, 1'b1, 4'h0, 8'h00, 32'h0, 1'b0, 8'hA0}, 1'b0, 1'b0, 32'hCAFEF00D, 1'b1);

        // Reset in the second WAIT cycle drops the access
        @(negedge clk_in);
        applyStimulus(0, 1'b0, 1'b0, 1'b1, 8'h55, 32'h0, 4'h0);
        waitGrant(who);
        checkOutput("rst_mid_grant", 64'(who), 64'd0);
        @(negedge clk_in);
        req0_valid = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        rst = 1'b1;
        @(negedge clk_in);
        rst = 1'b0;
        checkOutput("rst_mid_packet", 64'(packet), 64'(IDLE_EXP));
        checkOutput("rst_mid_busy", 64'(busy), 64'd0);
        checkOutput("rst_mid_rsp", 64'(rsp_valid), 64'd0);
        checkOutput("rst_mid_cs", 64'(chip_select), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            checkOutput("rst_mid_no_rsp", 64'(rsp_valid), 64'd0);
        end
        applyStimulus(1, 1'b0, 1'b0, 1'b1, 8'h66, 32'h0, 4'h0);
        waitGrant(who);
        checkOutput("post_rst_grant", 64'(who), 64'd1);
        trackRead("post_rst", {1'b0, 1'b1, 4'h0, 8'h66, 32'h0, 1'b1, 8'h00}, 1'b1, 1'b1, 32'h0BADC0DE, 1'b1);

        // Idle: packet stays idle and chip_select keeps SRAM1 selected
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            checkOutput("idle_packet", 64'(packet), 64'(IDLE_EXP));
            checkOutput("idle_cs", 64'(chip_select), 64'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sram_access_sequencer.md
Name: sram_access_sequencer

Overview:
- Sequences every access to the two test-chip SRAM macros (RW port and RO port on each).
- Arbitrates between two requesters: req0 is the picorv management path, req1 is the on-chip BIST/pattern engine.
- Builds the 55-bit access packet and chip_select that drive the SRAM input router, then waits the fixed pipeline latency and captures the returned read word from the SRAM output mux.
- Exactly one access is outstanding at a time; response order equals issue order.

Parameters:
- RD_LAT, 4: cycles from the packet-active cycle to the cycle in which rd_data is valid. Legal range 1..15.
- WR_GAP, 2: idle cycles inserted after a write before the next grant. Legal range 0..15.

Ports:
- clk_in  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- reqN_valid  in  1  request valid, N = 0,1.
- reqN_ready  out  1  request accepted when valid && ready.
- reqN_we  in  1  1 = write. Ignored when reqN_port = 1.
- reqN_port  in  1  0 = RW port, 1 = RO port.
- reqN_sram  in  1  target SRAM, 0 or 1.
- reqN_addr  in  8  word address.
- reqN_wdata  in  32  write data.
- reqN_wmask  in  4  byte write mask.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_id  out  1  requester that owns the response.
- rsp_rdata  out  32  read data; 0 for writes.
- packet  out  55  SRAM access packet.
- chip_select  out  1  SRAM select to the router and output mux.
- rd_data  in  32  returned SRAM word.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Packet fields:
  - [54] ena, active-low.
  - [53] wen, active-low.
  - [52:49] wen_mask.
  - [48:41] addr.
  - [40:9] wdata.
  - [8] ena_ro, active-low.
  - [7:0] addr_ro.
- IDLE_PKT has bits 54, 53 and 8 set and all other bits 0. packet = IDLE_PKT in every cycle except ISSUE.
- Reset values: state = IDLE, packet = IDLE_PKT, chip_select = 0, rsp_valid = 0, rsp_id = 0, rsp_rdata = 0, last_grant = 1 (so req0 wins the first tie), busy = 0, both ready = 0.
- Arbitration: round-robin between the two requesters.
  - Only one requester valid: that requester wins.
  - Both valid: the requester not equal to last_grant wins.
  - reqN_ready = (state == IDLE) && (grant == N), combinational.
  - At most one ready is high per cycle.
  - On acceptance: latch the request fields, update last_grant, go to ISSUE.
- States (all transitions are registered):
  - IDLE: wait for acceptance.
  - ISSUE (1 cycle):
    - packet is built from the latched request.
    - RW read: ena = 0, wen = 1, addr set, wdata = 0, mask = 0, ena_ro = 1, addr_ro = 0.
    - RW write: ena = 0, wen = 0, mask and wdata set.
    - RO read: ena = 1, wen = 1, ena_ro = 0, addr_ro = addr.
    - chip_select = latched sram, set in the same cycle.
    - Next state: reads go to WAIT, counter = RD_LAT - 1. Writes go to WRDONE.
  - WAIT: decrement the counter each cycle. When it reaches 0, sample rd_data and go to RESP.
    - RD_LAT = 1 skips WAIT: rd_data is sampled in the cycle after ISSUE.
  - RESP (1 cycle): rsp_valid = 1, rsp_id = owner, rsp_rdata = captured word. Next state is IDLE.
  - WRDONE (1 cycle): rsp_valid = 1, rsp_rdata = 0. Next state is GAP with counter = WR_GAP, or IDLE if WR_GAP = 0.
  - GAP: count down to 0, then go to IDLE.
- chip_select holds its value from ISSUE until the next ISSUE, including while idle, so the output mux stays stable.
- Latency:
  - Read: acceptance cycle + 1 ISSUE + RD_LAT → rsp_valid RD_LAT + 2 cycles after acceptance.
  - Write: response 2 cycles after acceptance.
- No response backpressure: the consumer must accept rsp_valid.
- Requests must hold until ready. Changing fields while valid && !ready is allowed; the grant uses current-cycle values.
- rst asserted mid-operation (any state): the next cycle is the reset state, the pending access is dropped, no rsp_valid is produced, and packet returns to IDLE_PKT.

Decomposition:
- Package sram_seq_pkg holds:
  - packet field bit-position localparams;
  - the IDLE_PKT constant;
  - the state encoding (IDLE, ISSUE, WAIT, RESP, WRDONE, GAP);
  - a helper function build_packet(we, port, addr, wdata, wmask).
- One sub-module: rr_arb2, the two-way round-robin arbiter holding last_grant and producing grant and the ready terms.
- The FSM and counter live in the top module.

Test Plan:
- RW read, single requester: req0 read SRAM1 addr 0x3C; drive rd_data = 0xDEADBEEF at the sample cycle → exactly one ISSUE cycle with packet[54] = 0, packet[48:41] = 0x3C, chip_select = 1; rsp_valid 6 cycles after acceptance (RD_LAT = 4), rsp_id = 0, rsp_rdata = 0xDEADBEEF.
- RW write: req1 writes SRAM0 addr 0x05, wdata 0x12345678, mask 0xF → packet[53] = 0, packet[40:9] = 0x12345678; rsp_valid 2 cycles after acceptance with rsp_rdata = 0; next grant no earlier than 2 GAP cycles later.
- Fairness: both requesters valid continuously for 4 reads → grants alternate 0,1,0,1; each rsp_id matches issue order.
- RO port: req0 with port = 1, we = 1, addr 0xA0 → packet[8] = 0, packet[7:0] = 0xA0, packet[54] = 1, packet[53] = 1; treated as a read and returns rd_data.
- Reset during WAIT (2nd wait cycle) → next cycle packet = IDLE_PKT, busy = 0, no rsp_valid; following req1 is granted first with no stale response.
- Idle check: no valid inputs for 20 cycles → packet stays IDLE_PKT and chip_select is unchanged.
